// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared types and constants for the k-means frame feeder
package kmeans_pkg;
    typedef enum logic [1:0] {FILL, SEND, WAIT_RES} feeder_state_t;
    localparam int DATA_W_DEF  = 16;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/kmeans_frame_feeder_if.sv
// kmeans_frame_feeder_if: source ready/valid stream plus CORE input stream and result monitor
interface kmeans_frame_feeder_if
    import kmeans_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    modport slave  (input  s_valid, s_data, out_valid, output s_ready, in_valid, in_data);
    modport master (output s_valid, s_data, out_valid, input  s_ready, in_valid, in_data);
endinterface

// File: rtl/kmeans_sync_fifo.sv
// kmeans_sync_fifo: single-clock FIFO with first-word-fall-through read and occupancy count
module kmeans_sync_fifo
    import kmeans_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic          pop,
    output logic [WIDTH-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage array write, no reset needed on data
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/kmeans_frame_feeder.sv
// kmeans_frame_feeder: buffers source words and bursts whole frames into the k-means CORE
// Optional KMEANS_FEEDER_HEADER_EN prefixes each burst with a FRAME_LEN header word.
module kmeans_frame_feeder
    import kmeans_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    kmeans_frame_feeder_if.slave   bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
`ifdef KMEANS_FEEDER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int SEND_LEN = FRAME_LEN + HDR;
    localparam int CNT_W    = $clog2(SEND_LEN);
    localparam int OCC_W    = $clog2(FIFO_DEPTH) + 1;

    feeder_state_t     state, state_n;
    logic              push, pop, full, empty, send_word, seen, is_hdr, last;
    logic [OCC_W-1:0]  count;
    logic [DATA_W-1:0] rd_data, word_n;
    logic [CNT_W-1:0]  sent;

    assign bus.s_ready = !full && !rst;
    assign push        = bus.s_valid && bus.s_ready;
    assign busy        = state != FILL;
    assign last        = sent == CNT_W'(SEND_LEN - 1);
    assign is_hdr      = (HDR != 0) && (sent == '0);

    kmeans_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.s_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    // next state, FIFO pop and the word to present on the next cycle
    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        send_word  = 1'b0;
        word_n     = '0;
        frame_done = 1'b0;
        case (state)
            FILL: state_n = count >= OCC_W'(FRAME_LEN) ? SEND : FILL;
            SEND: begin
                send_word = 1'b1;
                pop       = !is_hdr && !empty;
                word_n    = is_hdr ? DATA_W'(FRAME_LEN) : rd_data;
                state_n   = last ? WAIT_RES : SEND;
            end
            WAIT_RES: begin
                frame_done = seen && !bus.out_valid;
                state_n    = frame_done ? FILL : WAIT_RES;
            end
            default: state_n = FILL;
        endcase
    end

    // burst position counter and result-burst tracker (only live in WAIT_RES)
    always_ff @(posedge clk) begin
        if (rst) begin
            sent <= '0;
            seen <= 1'b0;
        end else begin
            sent <= state == SEND ? sent + 1'b1 : '0;
            seen <= state == WAIT_RES && state_n == WAIT_RES && (seen || bus.out_valid);
        end
    end

    // registered CORE outputs and completed-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_valid <= 1'b0;
            bus.in_data  <= '0;
            frame_cnt    <= '0;
        end else begin
            bus.in_valid <= send_word;
            bus.in_data  <= word_n;
            frame_cnt    <= frame_cnt + FRAME_CNT_W'(frame_done);
        end
    end
endmodule

// File: tb/tb_kmeans_frame_feeder.sv
// tb_kmeans_frame_feeder: randomized self-checking bench with a queue-based frame model
module tb_kmeans_frame_feeder;
    import kmeans_pkg::*;
    localparam int FL = 64;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, frame_done;
    logic [15:0] frame_cnt;
    int checks = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    int exp_cnt = 0;

    kmeans_frame_feeder_if #(.DATA_W(16)) bus ();

    kmeans_frame_feeder #(.DATA_W(16), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // push n random words; each accepted word joins the expected stream
    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            int g;
            w = 16'($urandom);
            g = 0;
            bus.s_valid = 1'b1;
            bus.s_data  = w;
            while (!bus.s_ready && g < 1000) begin
                tick();
                g++;
            end
            if (g >= 1000) begin
                checks++;
                fails++;
                $display("FAIL push_timeout: s_ready stayed %b, required 1", bus.s_ready);
                break;
            end
            tick();
            exp_q.push_back(w);
        end
        bus.s_valid = 1'b0;
    endtask

    // wait (bounded) for a burst and check n contiguous words in FIFO order
    task automatic wait_burst(input int n, input bit toggle);
        int g = 0;
        while (!bus.in_valid && g < 500) begin
            tick();
            g++;
        end
        checks++;
        if (!bus.in_valid) begin
            fails++;
            $display("FAIL burst_start: in_valid=%b, required 1", bus.in_valid);
        end
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
            bus.out_valid = (toggle && i < n - 1) ? 1'($urandom) : 1'b0;
            checks++;
            if (bus.in_valid !== 1'b1 || bus.in_data !== e || frame_done !== 1'b0) begin
                fails++;
                $display("FAIL burst_word[%0d]: in_valid=%b in_data=%h frame_done=%b, required 1 %h 0",
                         i, bus.in_valid, bus.in_data, frame_done, e);
            end
            tick();
        end
        bus.out_valid = 1'b0;
        checks++;
        if (bus.in_valid !== 1'b0 || bus.in_data !== 16'h0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL burst_end: in_valid=%b in_data=%h busy=%b, required 0 0000 1",
                     bus.in_valid, bus.in_data, busy);
        end
    endtask

    // CORE result burst of given length, then expect one frame_done pulse
    task automatic respond(input int highs);
        bus.out_valid = 1'b1;
        repeat (highs) tick();
        bus.out_valid = 1'b0;
        #1;
        checks++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse: frame_done=%b, required 1", frame_done);
        end
        exp_cnt++;
        tick();
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== 16'(exp_cnt) || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_after: frame_done=%b frame_cnt=%0d busy=%b, required 0 %0d 0",
                     frame_done, frame_cnt, busy, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_s_ready: s_ready=%b, required 0", bus.s_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.in_valid !== 1'b0 || bus.in_data !== 16'h0 ||
            busy !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: s_ready=%b in_valid=%b in_data=%h busy=%b done=%b cnt=%0d, required 1 0 0000 0 0 0",
                     bus.s_ready, bus.in_valid, bus.in_data, busy, frame_done, frame_cnt);
        end
    endtask

    // one frame with exact latency: accept edge, FILL decision edge, first word
    task automatic test_single_frame();
        push_words(FL);
        checks++;
        if (bus.in_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL lat_accept: in_valid=%b busy=%b, required 0 0", bus.in_valid, busy);
        end
        tick();
        checks++;
        if (bus.in_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL lat_send: in_valid=%b busy=%b, required 0 1", bus.in_valid, busy);
        end
        tick();
        checks++;
        if (bus.in_valid !== 1'b1) begin
            fails++;
            $display("FAIL lat_first: in_valid=%b, required 1", bus.in_valid);
        end
        wait_burst(FL, 1'b0);
        respond(4);
    endtask

    task automatic test_partial();
        bit seen_valid = 1'b0;
        push_words(FL - 1);
        repeat (100) begin
            tick();
            seen_valid |= bus.in_valid;
        end
        checks++;
        if (seen_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL partial_idle: in_valid_seen=%b busy=%b, required 0 0", seen_valid, busy);
        end
        push_words(1);
        tick();
        tick();
        checks++;
        if (bus.in_valid !== 1'b1) begin
            fails++;
            $display("FAIL partial_start: in_valid=%b, required 1", bus.in_valid);
        end
        wait_burst(FL, 1'b0);
        respond(2);
    endtask

    // continuous source: burst 1 while the FIFO fills to capacity, then bursts 2 and 3
    task automatic test_back_to_back();
        fork
            push_words(FL + DEPTH);
            wait_burst(FL, 1'b0);
        join
        checks++;
        if (bus.s_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL full_s_ready: s_ready=%b busy=%b, required 0 1", bus.s_ready, busy);
        end
        respond(4);
        wait_burst(FL, 1'b0);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_s_ready: s_ready=%b, required 1", bus.s_ready);
        end
        respond(4);
        wait_burst(FL, 1'b0);
        respond(1);
    endtask

    // out_valid noise during SEND ignored; low-high-high-low in WAIT_RES
    task automatic test_out_valid_ignore();
        logic [3:0] pat;
        logic [3:0] want;
        pat  = 4'b0110;
        want = 4'b1000;
        push_words(FL);
        wait_burst(FL, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.out_valid = pat[i];
            #1;
            checks++;
            if (frame_done !== want[i]) begin
                fails++;
                $display("FAIL wait_pattern[%0d]: frame_done=%b, required %b", i, frame_done, want[i]);
            end
            if (i < 3) tick();
        end
        exp_cnt++;
        tick();
        checks++;
        if (frame_cnt !== 16'(exp_cnt) || busy !== 1'b0) begin
            fails++;
            $display("FAIL pattern_cnt: frame_cnt=%0d busy=%b, required %0d 0", frame_cnt, busy, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_send();
        int g = 0;
        push_words(FL);
        while (!bus.in_valid && g < 500) begin
            tick();
            g++;
        end
        repeat (20) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.in_valid !== 1'b0 || frame_cnt !== 16'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort: in_valid=%b frame_cnt=%0d busy=%b, required 0 0 0", bus.in_valid, frame_cnt, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_s_ready: s_ready=%b, required 1", bus.s_ready);
        end
        exp_q.delete();
        exp_cnt = 0;
        push_words(FL);
        wait_burst(FL, 1'b0);
        respond(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.out_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_partial();
        test_back_to_back();
        test_out_valid_ignore();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule
